// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//   Round-robin arbiter for one shared tristate bus. Each requester feeds a
//   tristate buffer (O = E ? Q : z). This block owns every buffer enable, so
//   at most one driver is active. One fully released turnaround cycle sits
//   between any two tenures.
//
//   Optional feature macro: BUS_ARB_TIMEOUT_EN
//     defined   : a tenure is pre-empted after MAX_HOLD GRANT cycles, and
//                 timeout pulses for one cycle.
//     undefined : no tenure counter is built, timeout is tied to 0, and a
//                 tenure lasts as long as the owner holds req.
//
// Parameters
//   N        number of requesters (2..8)
//   W        bus data width
//   MAX_HOLD max consecutive GRANT cycles per tenure (timeout build only)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   req      in   N    request lines; the owner holds its bit for the whole tenure
//   din      in   N*W  requester data, slice i = din[i*W +: W]
//   gnt      out  N    registered one-hot grant
//   en       out  N    registered buffer enables, equal to gnt
//   bus      out  W    owner's din slice while granted, otherwise all z
//   busy     out  1    high while in GRANT
//   timeout  out  1    one-cycle pulse when a tenure is pre-empted
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   en,
  output logic [W-1:0]   bus,
  output logic           busy,
  output logic           timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8 || MAX_HOLD < 1) begin : g_bad_param
    $error("tristate_bus_arbiter: N must be 2..8 and MAX_HOLD >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // First set request in search order ptr, ptr+1, ... wrapping modulo N.
  function automatic logic [PW-1:0] pick(input logic [N-1:0] r,
                                         input logic [PW-1:0] p);
    logic [PW-1:0] res;
    logic [PW-1:0] idx;
    logic          found;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(p) + k) % N);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    busy_d  = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      // IDLE and TURN share the arbitration path; TURN always lasts one
      // cycle because it exits to GRANT or IDLE unconditionally.
      S_IDLE, S_TURN: begin
        if (|req) begin
          owner_d = pick(req, ptr_q);
          gnt_d   = onehot(owner_d);
          busy_d  = 1'b1;
          state_d = S_GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d   = CW'(1);
`endif
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!req[owner_q]) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = next_idx(owner_q);
          state_d = S_TURN;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        // cnt_q counts GRANT cycles of this tenure including the current one.
        else if (cnt_q == CW'(MAX_HOLD)) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = next_idx(owner_q);
          timeout_d = 1'b1;
          state_d   = S_TURN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign en   = gnt_q;
  assign busy = busy_q;

`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Tristate stage driven only from registered enables, so the bus cannot
  // glitch between owners.
  assign bus = (|gnt_q) ? din[owner_q*W +: W] : {W{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Testbench for tristate_bus_arbiter. Directed vectors push the expected
// post-edge response into a queue; a monitor pops the queue after each rising
// edge and compares. A random phase then checks the bus invariants.
module tb_tristate_bus_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [N-1:0]   en;
  logic [W-1:0]   bus;
  logic           busy;
  logic           timeout;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .en      (en),
    .bus     (bus),
    .busy    (busy),
    .timeout (timeout)
  );

  typedef struct {
    string        nm;
    logic [N-1:0] g;
    logic         t;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   passed   = 0;
  int   rand_bad = 0;
  bit   rand_phase = 1'b0;

  function automatic logic [W-1:0] exp_bus(input logic [N-1:0] g);
    logic [W-1:0] v;
    v = {W{1'bz}};
    for (int i = 0; i < N; i++)
      if (g[i]) v = din[i*W +: W];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle of stimulus and queue the response expected after the
  // following rising edge.
  task automatic s(input string nm, input logic rn, input logic [N-1:0] r,
                   input logic [N-1:0] eg, input logic et = 1'b0);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    req   = r;
    e.nm  = nm;
    e.g   = eg;
    e.t   = et;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t         e;
    logic [N-1:0] prev_en;
    prev_en = '0;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, "_gnt"},  32'(gnt),  32'(e.g));
        chk({e.nm, "_en"},   32'(en),   32'(e.g));
        chk({e.nm, "_bus"},  32'(bus),  32'(exp_bus(e.g)));
        chk({e.nm, "_busy"}, 32'(busy), 32'(|e.g));
        chk({e.nm, "_tmo"},  32'(timeout), 32'(e.t));
      end else if (rand_phase) begin
        if (!$onehot0(en)) rand_bad++;
        if (en !== gnt) rand_bad++;
        if (busy !== (|en)) rand_bad++;
        if (prev_en != '0 && en != '0 && en != prev_en) rand_bad++;
        for (int i = 0; i < N; i++)
          if (busy && en[i] && bus !== din[i*W +: W]) rand_bad++;
        if (!busy && bus !== {W{1'bz}}) rand_bad++;
      end
      prev_en = en;
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    req   = '0;
    din   = 32'hD3C2B1A0;

    // Reset with all requests pending, then first grant after release.
    s("rst_a",   1'b0, 4'b1111, 4'b0000);
    s("rst_b",   1'b0, 4'b1111, 4'b0000);
    s("rst_rel", 1'b1, 4'b1111, 4'b0001);
    s("t1_hold", 1'b1, 4'b1111, 4'b0001);
    s("t1_drop", 1'b1, 4'b0000, 4'b0000);
    s("t1_idle", 1'b1, 4'b0000, 4'b0000);

    // Two requesters alternating, three GRANT cycles each (ptr starts at 1).
    for (int i = 0; i < 3; i++) s("t2_g1", 1'b1, 4'b1010, 4'b0010);
    s("t2_turn1", 1'b1, 4'b1000, 4'b0000);
    for (int i = 0; i < 3; i++) s("t2_g3", 1'b1, 4'b1010, 4'b1000);
    s("t2_turn2", 1'b1, 4'b0010, 4'b0000);
    s("t2_g1b",   1'b1, 4'b0010, 4'b0010);
    s("t2_drop",  1'b1, 4'b0000, 4'b0000);
    s("t2_idle",  1'b1, 4'b0000, 4'b0000);

    // Sole requester pulses low for one cycle and is re-granted after TURN.
    s("t3_g2a",  1'b1, 4'b0100, 4'b0100);
    s("t3_g2b",  1'b1, 4'b0100, 4'b0100);
    s("t3_turn", 1'b1, 4'b0000, 4'b0000);
    s("t3_g2c",  1'b1, 4'b0100, 4'b0100);
    s("t3_g2d",  1'b1, 4'b0100, 4'b0100);
    s("t3_drop", 1'b1, 4'b0000, 4'b0000);
    s("t3_idle", 1'b1, 4'b0000, 4'b0000);

    // Reset mid-tenure; afterwards ptr=0 must pick 1 over 3 (old ptr was 3).
    s("t4_g1a",  1'b1, 4'b0010, 4'b0010);
    s("t4_g1b",  1'b1, 4'b0010, 4'b0010);
    s("t4_rst",  1'b0, 4'b1010, 4'b0000);
    s("t4_rel",  1'b1, 4'b1010, 4'b0010);
    s("t4_turn", 1'b1, 4'b1000, 4'b0000);
    s("t4_g3",   1'b1, 4'b1000, 4'b1000);
    s("t4_drop", 1'b1, 4'b0000, 4'b0000);
    s("t4_idle", 1'b1, 4'b0000, 4'b0000);

`ifdef BUS_ARB_TIMEOUT_EN
    // Two persistent requesters, each pre-empted after four GRANT cycles.
    for (int i = 0; i < 4; i++) s("t5_g0", 1'b1, 4'b0011, 4'b0001);
    s("t5_tmo0", 1'b1, 4'b0011, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) s("t5_g1", 1'b1, 4'b0011, 4'b0010);
    s("t5_tmo1", 1'b1, 4'b0011, 4'b0000, 1'b1);
    s("t5_idle", 1'b1, 4'b0000, 4'b0000);
`else
    // Without pre-emption a held request keeps the bus indefinitely.
    for (int i = 0; i < 6; i++) s("t5_g0", 1'b1, 4'b0011, 4'b0001);
    s("t5_drop", 1'b1, 4'b0000, 4'b0000);
    s("t5_idle", 1'b1, 4'b0000, 4'b0000);
`endif

    // Random requests and data; the monitor checks invariants each cycle.
    @(negedge clk);
    rand_phase = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      req = N'($urandom);
      din = $urandom;
      @(negedge clk);
    end
    rand_phase = 1'b0;
    req = '0;
    din = 32'hD3C2B1A0;

    s("end_rst", 1'b0, 4'b0000, 4'b0000);
    s("end_rel", 1'b1, 4'b0100, 4'b0100);
    repeat (3) @(negedge clk);

    chk("rand_invariants", 32'(rand_bad), 32'd0);
    chk("queue_drained",   32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
